// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared req/ack memory port.
// Define MC_PERF_CNT_EN to build the cycle and retired-instruction counters; otherwise both ports read 0.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic [2:0]       pc_sel,
    output logic             reg_write,
    output logic [2:0]       reg_sel,
    output logic             alu_src,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    // state  | meaning
    // IDLE   | post-reset, one cycle before the first fetch
    // FETCH  | instruction read at PC, IR loads on ack
    // DECODE | opcode legality check
    // EXEC   | ALU operation; branches retire here
    // MEM    | data access at ALU result; stores retire on ack
    // WB     | register writeback and PC update
    // TRAP   | illegal opcode, held until reset
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [2:0] PC_ALU = 3'b000;
    localparam logic [2:0] PC_P4  = 3'b010;
    localparam logic [2:0] PC_IMM = 3'b011;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_br;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc;
    logic w_legal, w_imm;

    assign w_is_r     = (opcode == 7'b0110011);
    assign w_is_i     = (opcode == 7'b0010011);
    assign w_is_load  = (opcode == 7'b0000011);
    assign w_is_store = (opcode == 7'b0100011);
    assign w_is_br    = (opcode == 7'b1100011);
    assign w_is_jal   = (opcode == 7'b1101111);
    assign w_is_jalr  = (opcode == 7'b1100111);
    assign w_is_lui   = (opcode == 7'b0110111);
    assign w_is_auipc = (opcode == 7'b0010111);
    assign w_legal    = w_is_r | w_is_i | w_is_load | w_is_store | w_is_br |
                        w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;
    assign w_imm      = w_is_i | w_is_load | w_is_store | w_is_jalr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:   w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (w_is_br)                       w_state_nxt = S_FETCH;
                else if (w_is_load || w_is_store)  w_state_nxt = S_MEM;
                else                               w_state_nxt = S_WB;
            end
            S_MEM: begin
                if (!mem_ack)        w_state_nxt = S_MEM;
                else if (w_is_store) w_state_nxt = S_FETCH;
                else                 w_state_nxt = S_WB;
            end
            S_WB:     w_state_nxt = S_FETCH;
            S_TRAP:   w_state_nxt = S_TRAP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_ALU;
        reg_write = 1'b0;
        reg_sel   = 3'b000;
        alu_src   = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
            end
            S_EXEC: begin
                alu_src = w_imm;
                if (w_is_br) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_IMM : PC_P4;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                alu_src  = 1'b1;
                mem_we   = w_is_store;
                if (mem_ack) begin
                    mdr_we = w_is_load;
                    if (w_is_store) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_P4;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
                alu_src   = w_imm;
                if (w_is_load)                  reg_sel = 3'b001;
                else if (w_is_jal || w_is_jalr) reg_sel = 3'b010;
                else if (w_is_auipc)            reg_sel = 3'b011;
                else if (w_is_lui)              reg_sel = 3'b100;
                if (w_is_jal)       pc_sel = PC_IMM;
                else if (w_is_jalr) pc_sel = PC_ALU;
                else                pc_sel = PC_P4;
            end
            default: ;
        endcase
    end

    assign illegal = (r_state == S_TRAP);
    assign state   = r_state;

`ifdef MC_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    // TRAP freezes both counters so the values at the fault stay readable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else if (r_state != S_TRAP) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            if (pc_we) r_instret_cnt <= r_instret_cnt + CNT_ONE;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
